// File: rtl/prog_loader_pkg.sv
// Shared encodings and widths for the boot-time program loader.
// The IF stage uses the same address and data widths.
package prog_loader_pkg;

   localparam int IMEM_AW = 8;
   localparam int DW      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CSUM  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_t;

   // States in which a frame is in flight and bytes may be accepted
   function automatic logic is_frame_state(input state_t s);
      return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags the cycle on which the TIMEOUT-th idle cycle completes.
module prog_loader_timer #(
   parameter int TIMEOUT = 1000,
   parameter int TW      = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TW-1:0] LP_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_count;

   // Idle-cycle counter; holds at the terminal value instead of wrapping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable && (r_count != LP_LAST)) begin
         r_count <= r_count + TW'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign expired = enable & ~clear & (r_count == LP_LAST);

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: receives a length/payload/checksum frame, writes the
// payload into instruction memory from address 0 and releases the core.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int TIMEOUT = 1000,
   parameter int TW      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [DW-1:0]      in_data,
   output logic               in_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [DW-1:0]      imem_wdata,
   output logic               core_run,
   output logic               load_err,
   output logic               busy
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IMEM_AW:0]   r_left;
   logic [IMEM_AW-1:0] r_ptr;
   logic [DW-1:0]      r_sum;
   logic               r_in_ready;
   logic               r_busy;
   logic               r_core_run;
   logic               r_load_err;
   logic               r_we;
   logic [IMEM_AW-1:0] r_addr;
   logic [DW-1:0]      r_wdata;

   logic               w_accept;
   logic               w_load_start;
   logic               w_last_byte;
   logic [DW-1:0]      w_csum_total;
   logic               w_frame;
   logic               w_expired;
   logic               w_in_ready_nxt;
   logic               w_core_run_nxt;
   logic               w_load_err_nxt;

   assign w_accept     = in_valid & r_in_ready;
   assign w_frame      = is_frame_state(r_state);
   assign w_load_start = start & ~w_frame;
   assign w_last_byte  = (r_left == {{IMEM_AW{1'b0}}, 1'b1});
   assign w_csum_total = r_sum + in_data;

   prog_loader_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (w_accept | ~w_frame),
      .enable  (w_frame),
      .expired (w_expired)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an accepted byte always takes priority over timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               w_state_nxt = ST_LEN;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_LEN: begin
            if (w_accept) begin
               w_state_nxt = ST_DATA;
            end else if (w_expired) begin
               w_state_nxt = ST_ERROR;
            end else begin
               w_state_nxt = ST_LEN;
            end
         end
         ST_DATA: begin
            if (w_accept && w_last_byte) begin
               w_state_nxt = ST_CSUM;
            end else if (w_accept) begin
               w_state_nxt = ST_DATA;
            end else if (w_expired) begin
               w_state_nxt = ST_ERROR;
            end else begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (w_accept) begin
               w_state_nxt = (w_csum_total == {DW{1'b0}}) ? ST_DONE : ST_ERROR;
            end else if (w_expired) begin
               w_state_nxt = ST_ERROR;
            end else begin
               w_state_nxt = ST_CSUM;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so the registered flags track r_state
   always_comb begin
      w_in_ready_nxt = 1'b0;
      w_core_run_nxt = 1'b0;
      w_load_err_nxt = 1'b0;
      case (w_state_nxt)
         ST_LEN, ST_DATA, ST_CSUM: w_in_ready_nxt = 1'b1;
         ST_DONE:                  w_core_run_nxt = 1'b1;
         ST_ERROR:                 w_load_err_nxt = 1'b1;
         default: begin
            w_in_ready_nxt = 1'b0;
            w_core_run_nxt = 1'b0;
            w_load_err_nxt = 1'b0;
         end
      endcase
   end

   // Registered status outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_core_run <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_in_ready <= w_in_ready_nxt;
         r_busy     <= w_in_ready_nxt;
         r_core_run <= w_core_run_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   // Payload datapath: byte count, write pointer, running sum and write port
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_left  <= '0;
         r_ptr   <= '0;
         r_sum   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_load_start) begin
            r_left <= '0;
            r_ptr  <= '0;
            r_sum  <= '0;
         end else if (w_accept && (r_state == ST_LEN)) begin
            // A length byte of zero encodes a full 256-byte payload
            r_left <= (in_data == {DW{1'b0}}) ? {1'b1, {IMEM_AW{1'b0}}}
                                               : {1'b0, in_data};
         end else if (w_accept && (r_state == ST_DATA)) begin
            r_we    <= 1'b1;
            r_addr  <= r_ptr;
            r_wdata <= in_data;
            r_ptr   <= r_ptr + {{(IMEM_AW-1){1'b0}}, 1'b1};
            r_sum   <= r_sum + in_data;
            r_left  <= r_left - {{IMEM_AW{1'b0}}, 1'b1};
         end else begin
            r_left <= r_left;
            r_ptr  <= r_ptr;
            r_sum  <= r_sum;
         end
      end
   end

   assign in_ready   = r_in_ready;
   assign busy       = r_busy;
   assign core_run   = r_core_run;
   assign load_err   = r_load_err;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (TIMEOUT = 8).
module tb_prog_loader;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [7:0] imem_wdata;
   logic       core_run;
   logic       load_err;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] wr_addr_q[$];
   logic [7:0] wr_data_q[$];
   int         wr_cyc_q[$];

   prog_loader #(.TIMEOUT(8), .TW(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_run   (core_run),
      .load_err   (load_err),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   // Write monitor: record every memory write with its cycle stamp
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
         wr_cyc_q.push_back(cyc);
      end
   end

   task automatic clear_writes();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Hold in_valid low for gap cycles, then present b until accepted
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      got = 1'b0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clock);
      in_valid = 1'b1;
      in_data  = b;
      for (int k = 0; k < 20 && !got; k++) begin
         got = (in_ready === 1'b1);
         @(negedge clock);
      end
      in_valid = 1'b0;
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_byte: byte %h not accepted, in_ready=%b required 1", b, in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({in_ready, busy, core_run, load_err, imem_we, imem_addr, imem_wdata} !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b %b %b %b %b %h %h, required all 0",
                  in_ready, busy, core_run, load_err, imem_we, imem_addr, imem_wdata);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: status %b required 0000", {in_ready, busy, core_run, load_err});
      end
   endtask

   task automatic test_good_frame();
      logic [7:0] exp_d[3];
      exp_d = '{8'h10, 8'h20, 8'h30};
      clear_writes();
      pulse_start();
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b1100) begin
         n_fail++;
         $display("FAIL good_start: status %b required 1100", {in_ready, busy, core_run, load_err});
      end
      send_byte(8'd3, 0);
      for (int i = 0; i < 3; i++) send_byte(exp_d[i], 0);
      send_byte(8'hA0, 0);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0010) begin
         n_fail++;
         $display("FAIL good_done: status %b required 0010", {in_ready, busy, core_run, load_err});
      end
      n_checks++;
      if (wr_addr_q.size() !== 3) begin
         n_fail++;
         $display("FAIL good_wcount: got %0d writes, required 3", wr_addr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({wr_addr_q[i], wr_data_q[i]} !== {i[7:0], exp_d[i]}) begin
               n_fail++;
               $display("FAIL good_write%0d: got (%h,%h) required (%h,%h)",
                        i, wr_addr_q[i], wr_data_q[i], i[7:0], exp_d[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 1) begin
               n_fail++;
               $display("FAIL good_b2b%0d: write spacing %0d cycles, required 1",
                        i, wr_cyc_q[i] - wr_cyc_q[i-1]);
            end
         end
      end
   endtask

   task automatic test_bad_checksum();
      clear_writes();
      pulse_start();
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b1100) begin
         n_fail++;
         $display("FAIL bad_start_clears_run: status %b required 1100", {in_ready, busy, core_run, load_err});
      end
      send_byte(8'd3, 0);
      send_byte(8'h10, 0);
      send_byte(8'h20, 0);
      send_byte(8'h30, 0);
      send_byte(8'hA1, 0);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0001) begin
         n_fail++;
         $display("FAIL bad_error: status %b required 0001", {in_ready, busy, core_run, load_err});
      end
      n_checks++;
      if (wr_addr_q.size() !== 3 || wr_addr_q[2] !== 8'd2 || wr_data_q[2] !== 8'h30) begin
         n_fail++;
         $display("FAIL bad_writes: got %0d writes, required 3 ending (02,30)", wr_addr_q.size());
      end
   endtask

   task automatic test_len_zero();
      int bad;
      bad = 0;
      clear_writes();
      pulse_start();
      send_byte(8'h00, 0);
      for (int i = 0; i < 256; i++) send_byte(8'h01, 0);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b1100) begin
         n_fail++;
         $display("FAIL len0_csum_wait: status %b required 1100", {in_ready, busy, core_run, load_err});
      end
      send_byte(8'h00, 0);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0010) begin
         n_fail++;
         $display("FAIL len0_done: status %b required 0010", {in_ready, busy, core_run, load_err});
      end
      n_checks++;
      if (wr_addr_q.size() !== 256) begin
         n_fail++;
         $display("FAIL len0_wcount: got %0d writes, required 256", wr_addr_q.size());
      end else begin
         for (int i = 0; i < 256; i++)
            if (wr_addr_q[i] !== i[7:0] || wr_data_q[i] !== 8'h01) bad++;
         n_checks++;
         if (bad !== 0) begin
            n_fail++;
            $display("FAIL len0_writes: %0d writes wrong, required 0", bad);
         end
         n_checks++;
         if (wr_addr_q[255] !== 8'hFF) begin
            n_fail++;
            $display("FAIL len0_last_addr: got %h required ff", wr_addr_q[255]);
         end
      end
   endtask

   task automatic test_timeout();
      clear_writes();
      pulse_start();
      send_byte(8'd2, 0);
      send_byte(8'h55, 0);
      repeat (7) @(negedge clock);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b1100) begin
         n_fail++;
         $display("FAIL tmo_early: status %b after 7 idle cycles, required 1100", {in_ready, busy, core_run, load_err});
      end
      @(negedge clock);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0001) begin
         n_fail++;
         $display("FAIL tmo_error: status %b after 8 idle cycles, required 0001", {in_ready, busy, core_run, load_err});
      end
      n_checks++;
      if (wr_addr_q.size() !== 1 || wr_data_q[0] !== 8'h55) begin
         n_fail++;
         $display("FAIL tmo_writes: got %0d writes, required 1 of 55", wr_addr_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d[4];
      exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      clear_writes();
      pulse_start();
      send_byte(8'd4, 2);
      send_byte(exp_d[0], 7);
      in_valid = 1'b0;
      @(negedge clock);
      pulse_start();
      send_byte(exp_d[1], 3);
      send_byte(exp_d[2], 0);
      send_byte(exp_d[3], 7);
      send_byte(8'h56, 4);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0010) begin
         n_fail++;
         $display("FAIL bp_done: status %b required 0010", {in_ready, busy, core_run, load_err});
      end
      n_checks++;
      if (wr_addr_q.size() !== 4) begin
         n_fail++;
         $display("FAIL bp_wcount: got %0d writes, required 4", wr_addr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({wr_addr_q[i], wr_data_q[i]} !== {i[7:0], exp_d[i]}) begin
               n_fail++;
               $display("FAIL bp_write%0d: got (%h,%h) required (%h,%h)",
                        i, wr_addr_q[i], wr_data_q[i], i[7:0], exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      pulse_start();
      send_byte(8'd4, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({in_ready, busy, core_run, load_err, imem_we, imem_addr, imem_wdata} !== 21'h0) begin
         n_fail++;
         $display("FAIL async_reset: got %b %b %b %b %b %h %h, required all 0",
                  in_ready, busy, core_run, load_err, imem_we, imem_addr, imem_wdata);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      clear_writes();
      pulse_start();
      send_byte(8'd1, 0);
      send_byte(8'h77, 0);
      send_byte(8'h89, 0);
      n_checks++;
      if ({in_ready, busy, core_run, load_err} !== 4'b0010) begin
         n_fail++;
         $display("FAIL reload_done: status %b required 0010", {in_ready, busy, core_run, load_err});
      end
      n_checks++;
      if (wr_addr_q.size() !== 1 || {wr_addr_q[0], wr_data_q[0]} !== 16'h0077) begin
         n_fail++;
         $display("FAIL reload_write: got %0d writes, required 1 at (00,77)", wr_addr_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_len_zero();
      test_timeout();
      test_backpressure();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the 8-bit five-stage processor. It receives a framed byte stream (length, payload, checksum) over a valid/ready handshake and writes the payload into instruction memory starting at address 0. It holds the core stopped until a frame is loaded and verified. On success it raises `core_run` so IF begins fetching at PC 0; on failure it raises `load_err` and keeps the core stopped.

## Interface
- `TIMEOUT`, default 1000: maximum idle cycles allowed between accepted bytes while a frame is in progress.
- `TW`, default 16: width of the timeout counter. `TIMEOUT` must be less than 2^TW.

Ports:
- `clock`  in  1  single system clock. All state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a new load.
- `in_valid`  in  1  an incoming byte is present.
- `in_data`  in  8  the incoming byte.
- `in_ready`  out  1  loader can accept a byte.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  8  instruction-memory write address.
- `imem_wdata`  out  8  instruction-memory write data.
- `core_run`  out  1  processor may execute. Stays 0 while loading.
- `load_err`  out  1  last frame failed, by checksum or timeout.
- `busy`  out  1  a frame is in progress.

## Operation
- States:
  - IDLE
  - LEN: waiting for the length byte.
  - DATA: receiving payload bytes.
  - CSUM: waiting for the checksum byte.
  - DONE
  - ERROR
- Byte acceptance: a byte is accepted on a cycle where `in_valid && in_ready`. `in_ready` is 1 only in LEN, DATA and CSUM.
- `start`:
  - In IDLE, DONE or ERROR, `start` moves to LEN.
  - On that transition: clear the write pointer, the running sum, `load_err` and `core_run`.
  - `start` is ignored in LEN, DATA and CSUM.
- LEN state:
  - The accepted byte L sets the payload count N = L. L = 0 means N = 256.
  - Go to DATA.
- DATA state:
  - Each accepted byte is written to address `ptr`.
  - Then `ptr` increments (8-bit) and `sum` ← `sum` + byte (mod 256).
  - After the Nth byte, go to CSUM.
  - With N = 256, the last write goes to 255 and `ptr` wraps to 0; the wrap is harmless.
- CSUM state, on accepting byte C:
  - If (`sum` + C) mod 256 == 0, go to DONE. Otherwise go to ERROR.
- DONE: `core_run` = 1.
- ERROR: `load_err` = 1 and `core_run` = 0.
- Timeout:
  - In LEN, DATA and CSUM, the timer counts cycles without an accepted byte.
  - Any accepted byte, or entry into LEN, resets the timer to 0.
  - When the count reaches `TIMEOUT`, go to ERROR.
  - Memory already written stays written. `core_run` stays 0.
- Simultaneous events: if the timeout and an accepted byte fall on the same cycle, the byte wins. It is processed and the timer clears.
- `busy` = 1 in LEN, DATA and CSUM.

## Timing
- Reset (asynchronous, immediate): state IDLE, `ptr` = 0, `sum` = 0, timer = 0. All outputs are 0: `in_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `core_run`, `load_err`, `busy`.
- Write latency:
  - `imem_we` pulses high for exactly one cycle, in the cycle after a DATA byte is accepted.
  - `imem_addr` and `imem_wdata` are registered and valid during that pulse.
  - Back-to-back bytes give back-to-back write pulses.
- `core_run` rises in the cycle after the checksum byte is accepted, when the checksum passes.
- Minimum frame time: N+2 accepted bytes, plus 1 cycle to reach DONE.
- `in_ready` is a registered function of state, with no combinational path from `in_valid`.
- Reset mid-frame aborts immediately and returns to IDLE.

## Structure
- Shared package / header holds:
  - the state encoding constants (3-bit: IDLE=0, LEN=1, DATA=2, CSUM=3, DONE=4, ERROR=5);
  - the instruction-memory address width (8);
  - the data width (8).
  The IF stage uses the same widths.
- One sub-module, `prog_loader_timer`, provides:
  - inputs: clear, enable;
  - output: expired flag;
  - parameters: `TIMEOUT`, `TW`.
- The FSM, pointer and sum stay in `prog_loader`.

## Test plan
- Good frame:
  - Stimulus: reset, `start`, then bytes 3, 0x10, 0x20, 0x30, 0xA0 with no gaps. The payload sums to 0x60, and 0x60 + 0xA0 = 0x100.
  - Response: writes (0,0x10), (1,0x20), (2,0x30) on consecutive cycles; `core_run` = 1; `load_err` = 0.
- Bad checksum:
  - Stimulus: same frame with a final byte of 0xA1.
  - Response: ERROR; `load_err` = 1; `core_run` = 0; three writes still occur.
- Length 0:
  - Stimulus: 256 payload bytes of value 0x01, then checksum 0x00 (256 × 1 mod 256 = 0).
  - Response: last write at address 255; DONE.
- Timeout:
  - Stimulus: with `TIMEOUT` = 8, send length 2 and one byte, then hold `in_valid` low.
  - Response: ERROR exactly 8 cycles after the last accepted byte; `in_ready` = 0 afterwards.
- Backpressure and ignored start:
  - Stimulus: random gaps on `in_valid`, each gap shorter than `TIMEOUT`, plus a `start` pulse during DATA.
  - Response: no extra writes; `ptr` is not reset; the frame completes normally.
- Asynchronous reset:
  - Stimulus: assert `reset` between clock edges mid-DATA.
  - Response: all outputs 0 before the next edge; a new `start` then reloads from address 0.
